wts_wave_writer: RTL and testbench
==================================

Name: wts_wave_writer

Overview:
CPU-side write path into the wave table RAM of one Wave Table Sound channel. It is the counterpart of the channel's playback address sequencer.
- Buffers CPU sample writes in a small FIFO.
- Masks addresses to the active wave length.
- Commits writes to the RAM write port, either immediately or deferred to the half-wave boundary (sync mode).
- Never overwrites the sample currently being played.

Parameters:
FIFO_DEPTH, 4, write buffer entries; power of two, >= 2
DATA_WIDTH, 8, wave sample width in bits

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
active  in  1  3.579MHz timing pulse, one clk wide
cpu_wr  in  1  write request pulse; accepted when cpu_ready=1
cpu_address  in  7  target wave sample index
cpu_wdata  in  DATA_WIDTH  sample value
cpu_ready  out  1  FIFO not full
overflow  out  1  sticky: a write was dropped
clear_overflow  in  1  clears overflow
sync_mode  in  1  0 = immediate commit; 1 = commit at half boundary
reg_wave_length  in  2  wave length select, same encoding as the playback sequencer
wave_address  in  7  current playback address from the sequencer (already masked)
half_timing  in  1  half-wave boundary strobe from the sequencer
address_reset  in  1  playback restart; also acts as a drain trigger in sync mode
ram_we  out  1  wave RAM write enable, registered
ram_address  out  7  wave RAM write address, registered
ram_wdata  out  DATA_WIDTH  wave RAM write data, registered
busy  out  1  FIFO not empty or state != ST_IDLE

Behaviour:
Reset values:
- ram_we=0, ram_address=0, ram_wdata=0, overflow=0, cpu_ready=1, busy=0.
- FIFO empty, state ST_IDLE.
- Reset mid-operation discards all buffered entries.

Push:
- cpu_wr & !full: store {masked address, data}.
- Masked address = {reg_wave_length & cpu_address[6:5], cpu_address[4:0]}, using reg_wave_length at push time.
- cpu_wr & full: entry dropped, overflow <= 1.
- A pop in the same cycle does not make room; full is evaluated before the pop.
- clear_overflow together with a new drop: overflow stays 1.

Commit decision (per cycle, pop candidate = FIFO head):
- pop_ok = FIFO not empty & state permits & head address != wave_address.
- Collision (head address == wave_address): stall; retry every cycle.
- On pop: ram_we=1 with head address/data in the next cycle; otherwise ram_we=0.
- At most one commit per clk. FIFO order is preserved; entries never bypass each other.

States:
- ST_IDLE: sync_mode=0 → commits permitted. sync_mode=1 & FIFO not empty → ST_WAIT.
- ST_WAIT: no commits. active & (half_timing | address_reset) → ST_DRAIN.
- ST_DRAIN: commits permitted, including entries pushed during the drain. FIFO empty → ST_IDLE.
- sync_mode changing 1→0 while in ST_WAIT → ST_IDLE. Buffered entries then commit immediately.

Latency:
- Async mode, no collision: cpu_wr in cycle N → entry visible at N+1 → pop decision at N+1 → ram_we=1 in cycle N+2.
- Sync mode: first ram_we one cycle after the triggering active cycle (if no collision). Remaining entries follow on consecutive cycles.

cpu_ready = !full, combinational from FIFO count.

Decomposition:
Shared package wts_pkg:
- State encoding ST_IDLE/ST_WAIT/ST_DRAIN.
- WTS_ADDR_W=7.
- Wave-length encoding constants (shared with the playback sequencer).
- The address-mask function, so writer and sequencer mask identically.

One natural sub-module: wts_sync_fifo.
- Parameterised depth and width.
- Exposes push/pop/full/empty/head.
- Registered storage with head-of-queue read.

Test Plan:
1. sync_mode=0, wave_address=0x14; cpu_wr addr=0x05 data=0x3C at cycle N → ram_we=1, ram_address=0x05, ram_wdata=0x3C at N+2 only.
2. Collision: wave_address=0x05; write addr 0x05 data 0x11 → no ram_we while wave_address=0x05; wave_address→0x06 at cycle M → ram_we with 0x05/0x11 at M+1.
3. sync_mode=1: write (0x01,0xA1),(0x02,0xA2),(0x03,0xA3) → no ram_we, state ST_WAIT; active & half_timing at cycle K → ram_we at K+1, K+2, K+3 in that order; busy=0 afterwards.
4. Overflow: sync_mode=1, five writes with no trigger → four stored, cpu_ready=0 after the 4th, overflow=1 after the 5th, which is never committed; clear_overflow → overflow=0.
5. Masking: reg_wave_length=2'b00, write addr 0x65 → ram_address 0x05; reg_wave_length=2'b10, addr 0x65 → 0x45.
6. Reset during ST_DRAIN with 3 entries queued → ram_we=0 from the next cycle, busy=0, cpu_ready=1; the old entries are never written after reset releases.

Source files
------------

// File: rtl/wts_pkg.sv
// Shared definitions for the Wave Table Sound channel: state encoding,
// wave-length select codes and the sample-address mask used by writer and sequencer.
package wts_pkg;

    localparam int WTS_ADDR_W = 7;

    // Wave length select codes; bits [6:5] of a sample index survive only where set.
    localparam logic [1:0] WTS_WL_32    = 2'b00;
    localparam logic [1:0] WTS_WL_64    = 2'b01;
    localparam logic [1:0] WTS_WL_64_HI = 2'b10;
    localparam logic [1:0] WTS_WL_128   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } wts_state_e;

    function automatic logic [WTS_ADDR_W-1:0] wts_mask_address(
        input logic [1:0]            wave_length,
        input logic [WTS_ADDR_W-1:0] address
    );
        logic [1:0] hi_keep;
        case (wave_length)
            WTS_WL_32:    hi_keep = 2'b00;
            WTS_WL_64:    hi_keep = 2'b01;
            WTS_WL_64_HI: hi_keep = 2'b10;
            WTS_WL_128:   hi_keep = 2'b11;
            default:      hi_keep = 2'b00;
        endcase
        return {hi_keep & address[6:5], address[4:0]};
    endfunction

endpackage

// File: rtl/wts_sync_fifo.sv
// Small synchronous FIFO with registered storage and a head-of-queue read port.
// Push is ignored when full and pop is ignored when empty.
module wts_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    // Full is taken from the current count, so a same-cycle pop never makes room.
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wts_wave_writer.sv
// CPU write path into one channel's wave table RAM: buffers writes, masks them to
// the active wave length, and commits them without touching the sample being played.
module wts_wave_writer
    import wts_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  cpu_wr,
    input  logic [WTS_ADDR_W-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  overflow,
    input  logic                  clear_overflow,
    input  logic                  sync_mode,
    input  logic [1:0]            reg_wave_length,
    input  logic [WTS_ADDR_W-1:0] wave_address,
    input  logic                  half_timing,
    input  logic                  address_reset,
    output logic                  ram_we,
    output logic [WTS_ADDR_W-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  busy,
    output wts_state_e            dbg_state
);

    localparam int ENTRY_W = WTS_ADDR_W + DATA_WIDTH;

    // Handshake: a write is taken on any clk where cpu_wr=1 and cpu_ready=1;
    // cpu_wr while cpu_ready=0 drops the write and raises the sticky overflow flag.

    wts_state_e            state_q;
    wts_state_e            state_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [ENTRY_W-1:0]    push_entry;
    logic [WTS_ADDR_W-1:0] head_address;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  push;
    logic                  drop;
    logic                  pop;
    logic                  commit_permit;
    logic                  sync_trigger;

    assign push         = cpu_wr & ~fifo_full;
    assign drop         = cpu_wr & fifo_full;
    assign push_entry   = {wts_mask_address(reg_wave_length, cpu_address), cpu_wdata};
    assign head_address = fifo_head[ENTRY_W-1:DATA_WIDTH];
    assign head_data    = fifo_head[DATA_WIDTH-1:0];
    assign sync_trigger = active & (half_timing | address_reset);

    // The head stalls rather than overwrite the sample under the playback pointer.
    assign pop = ~fifo_empty & commit_permit & (head_address != wave_address);

    wts_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The trigger cycle itself may commit, so the first write lands one clk later.
    always_comb begin
        state_d       = state_q;
        commit_permit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                commit_permit = ~sync_mode;
                if (sync_mode && !fifo_empty) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!sync_mode) begin
                    state_d = ST_IDLE;
                end else if (sync_trigger) begin
                    state_d       = ST_DRAIN;
                    commit_permit = 1'b1;
                end
            end
            ST_DRAIN: begin
                commit_permit = 1'b1;
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_we      <= 1'b0;
            ram_address <= '0;
            ram_wdata   <= '0;
        end else begin
            ram_we <= pop;
            if (pop) begin
                ram_address <= head_address;
                ram_wdata   <= head_data;
            end
        end
    end

    // A fresh drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign cpu_ready = ~fifo_full;
    assign busy      = ~fifo_empty | (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wts_wave_writer.sv
// Self-checking bench for wts_wave_writer: directed scenarios plus a random run,
// all compared each cycle against a queue-based model of the write buffer.
module tb_wts_wave_writer;
    import wts_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          active = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [6:0]    cpu_address = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ready;
    logic          overflow;
    logic          clear_overflow = 1'b0;
    logic          sync_mode = 1'b0;
    logic [1:0]    reg_wave_length = 2'b11;
    logic [6:0]    wave_address = 7'h14;
    logic          half_timing = 1'b0;
    logic          address_reset = 1'b0;
    logic          ram_we;
    logic [6:0]    ram_address;
    logic [DW-1:0] ram_wdata;
    logic          busy;
    wts_state_e    dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model: pending writes in arrival order, plus the hold/drain modes.
    logic [6+DW:0] exp_q[$];
    logic          m_holding = 1'b0;
    logic          m_draining = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_we = 1'b0;
    logic [6:0]    m_addr = '0;
    logic [DW-1:0] m_data = '0;

    wts_wave_writer #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .active          (active),
        .cpu_wr          (cpu_wr),
        .cpu_address     (cpu_address),
        .cpu_wdata       (cpu_wdata),
        .cpu_ready       (cpu_ready),
        .overflow        (overflow),
        .clear_overflow  (clear_overflow),
        .sync_mode       (sync_mode),
        .reg_wave_length (reg_wave_length),
        .wave_address    (wave_address),
        .half_timing     (half_timing),
        .address_reset   (address_reset),
        .ram_we          (ram_we),
        .ram_address     (ram_address),
        .ram_wdata       (ram_wdata),
        .busy            (busy),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    // Wave length as an index range: 32, 64 (bit5 kept), 64 (bit6 kept), 128.
    function automatic logic [6:0] model_mask(input logic [1:0] wl, input logic [6:0] a);
        int v;
        v = int'(a);
        case (wl)
            2'b00:   return 7'(v % 32);
            2'b01:   return 7'(v % 64);
            2'b10:   return 7'((v % 32) + ((v >= 64) ? 64 : 0));
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic          nonempty;
        logic          full;
        logic          trig;
        logic          permit;
        logic          pop;
        logic [6+DW:0] head;
        wts_state_e    exp_state;
        nonempty = (exp_q.size() != 0);
        full     = (exp_q.size() == DEPTH);
        trig     = active & (half_timing | address_reset);
        permit   = m_draining | (!m_holding & !sync_mode) | (m_holding & sync_mode & trig);
        head     = nonempty ? exp_q[0] : '0;
        pop      = nonempty & permit & (head[6+DW:DW] != wave_address);
        @(posedge clk);
        #1;
        if (reset) begin
            exp_q.delete();
            m_holding = 1'b0; m_draining = 1'b0; m_ovf = 1'b0;
            m_we = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            m_we = pop;
            if (pop) begin
                m_addr = head[6+DW:DW];
                m_data = head[DW-1:0];
                void'(exp_q.pop_front());
            end
            if (cpu_wr && !full) exp_q.push_back({model_mask(reg_wave_length, cpu_address), cpu_wdata});
            if (cpu_wr && full) m_ovf = 1'b1;
            else if (clear_overflow) m_ovf = 1'b0;
            if (m_draining) begin
                if (!nonempty) m_draining = 1'b0;
            end else if (m_holding) begin
                if (!sync_mode) m_holding = 1'b0;
                else if (trig) begin m_holding = 1'b0; m_draining = 1'b1; end
            end else if (sync_mode && nonempty) begin
                m_holding = 1'b1;
            end
        end
        exp_state = m_draining ? ST_DRAIN : (m_holding ? ST_WAIT : ST_IDLE);
        check("ram_we", 32'(ram_we), 32'(m_we));
        check("ram_address", 32'(ram_address), 32'(m_addr));
        check("ram_wdata", 32'(ram_wdata), 32'(m_data));
        check("cpu_ready", 32'(cpu_ready), 32'(exp_q.size() < DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("busy", 32'(busy), 32'(exp_q.size() != 0 || m_holding || m_draining));
        check("state", 32'(dbg_state), 32'(exp_state));
    endtask

    task automatic write(input logic [6:0] a, input logic [DW-1:0] d);
        cpu_wr = 1'b1; cpu_address = a; cpu_wdata = d;
        cycle();
        cpu_wr = 1'b0;
    endtask

    task automatic trigger_half();
        active = 1'b1; half_timing = 1'b1;
        cycle();
        active = 1'b0; half_timing = 1'b0;
    endtask

    initial begin
        // Reset values
        reset = 1'b1;
        cycle(); cycle();
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        cycle();

        // Immediate commit two cycles after the write
        sync_mode = 1'b0; wave_address = 7'h14;
        write(7'h05, 8'h3C);
        check("t1_n1_we", 32'(ram_we), 32'd0);
        cycle();
        check("t1_n2_we", 32'(ram_we), 32'd1);
        check("t1_n2_addr", 32'(ram_address), 32'h05);
        check("t1_n2_data", 32'(ram_wdata), 32'h3C);
        cycle();
        check("t1_n3_we", 32'(ram_we), 32'd0);

        // Collision with the playback pointer stalls the head
        wave_address = 7'h05;
        write(7'h05, 8'h11);
        repeat (4) cycle();
        check("t2_stall_we", 32'(ram_we), 32'd0);
        wave_address = 7'h06;
        cycle();
        check("t2_m1_we", 32'(ram_we), 32'd1);
        check("t2_m1_data", 32'(ram_wdata), 32'h11);
        cycle();

        // Deferred commit at the half-wave boundary
        sync_mode = 1'b1; wave_address = 7'h40;
        write(7'h01, 8'hA1); write(7'h02, 8'hA2); write(7'h03, 8'hA3);
        repeat (3) cycle();
        check("t3_wait_state", 32'(dbg_state), 32'(ST_WAIT));
        check("t3_wait_we", 32'(ram_we), 32'd0);
        trigger_half();
        check("t3_k1_addr", 32'(ram_address), 32'h01);
        cycle();
        check("t3_k2_addr", 32'(ram_address), 32'h02);
        cycle();
        check("t3_k3_addr", 32'(ram_address), 32'h03);
        repeat (2) cycle();
        check("t3_busy", 32'(busy), 32'd0);

        // Overflow on the fifth buffered write
        for (int i = 0; i < 5; i++) begin
            write(7'(7'h10 + i), 8'(8'hB0 + i));
            if (i == 3) check("t4_ready_full", 32'(cpu_ready), 32'd0);
        end
        check("t4_overflow", 32'(overflow), 32'd1);
        clear_overflow = 1'b1; cycle(); clear_overflow = 1'b0;
        check("t4_cleared", 32'(overflow), 32'd0);
        trigger_half();
        repeat (6) cycle();
        check("t4_last_data", 32'(ram_wdata), 32'hB3);

        // Address masking by wave length
        sync_mode = 1'b0; wave_address = 7'h14; cycle();
        reg_wave_length = 2'b00;
        write(7'h65, 8'h55); cycle();
        check("t5_wl00_addr", 32'(ram_address), 32'h05);
        reg_wave_length = 2'b10;
        write(7'h65, 8'h56); cycle();
        check("t5_wl10_addr", 32'(ram_address), 32'h45);
        reg_wave_length = 2'b11;
        cycle();

        // Reset in the middle of a stalled drain
        sync_mode = 1'b1; wave_address = 7'h30;
        write(7'h30, 8'hC0); write(7'h31, 8'hC1); write(7'h32, 8'hC2);
        cycle();
        trigger_half();
        cycle();
        check("t6_drain_state", 32'(dbg_state), 32'(ST_DRAIN));
        reset = 1'b1; cycle(); reset = 1'b0;
        check("t6_rst_we", 32'(ram_we), 32'd0);
        check("t6_rst_ready", 32'(cpu_ready), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        wave_address = 7'h50; sync_mode = 1'b0;
        repeat (6) cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            cpu_wr          = ($urandom_range(0, 1) == 1);
            cpu_address     = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
            cpu_wdata       = 8'($urandom_range(0, 255));
            wave_address    = 7'($urandom_range(0, 7));
            active          = ($urandom_range(0, 2) == 0);
            half_timing     = ($urandom_range(0, 5) == 0);
            address_reset   = ($urandom_range(0, 9) == 0);
            clear_overflow  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) sync_mode = ~sync_mode;
            if ($urandom_range(0, 24) == 0) reg_wave_length = 2'($urandom_range(0, 3));
            cycle();
        end
        cpu_wr = 1'b0; active = 1'b0; half_timing = 1'b0; address_reset = 1'b0;
        clear_overflow = 1'b0;
        repeat (5) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
